frame_align: RTL
================

FRAME_ALIGN -- requirements
Module: frame_align

Interface
REQ-001 SHALL have parameter FRAME_PATTERN, default 8'hF0: expected deserialized frame-clock word when lanes are aligned.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4: wait cycles after start or after each bitslip before comparing.
REQ-003 SHALL have parameter MATCH_CYCLES, default 16: consecutive matches required to declare lock.
REQ-004 SHALL have parameter MAX_SLIPS, default 8 (range 1-15): bitslip pulses allowed before failure.
REQ-005 SHALL have parameter LOSS_CYCLES, default 4: consecutive mismatches in lock that declare loss of lock.
REQ-006 SHALL have port adc_clk, input, 1: deserializer divided clock, the only clock.
REQ-007 SHALL have port rst_adc, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port align_start, input, 1: single-cycle request to (re)start alignment, already synchronous to adc_clk.
REQ-009 SHALL have port frmData, input, 8: deserialized frame-clock word from the ADC capture stage.
REQ-010 SHALL have port bitslip, output, 1: single-cycle slip request to all ISERDES lanes.
REQ-011 SHALL have port aligned, output, 1: frame lock achieved and held.
REQ-012 SHALL have port align_err, output, 1: MAX_SLIPS exhausted without lock.
REQ-013 SHALL have port slip_count, output, 4: bitslip pulses issued in the current attempt.

Function
REQ-014 SHALL implement states IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL; all outputs registered.
REQ-015 IDLE: outputs held; align_start -> SETTLE, clearing slip_count, settle/match/loss counters, aligned, align_err.
REQ-016 SETTLE: ignore frmData for exactly SETTLE_CYCLES cycles, then -> CHECK with match counter 0.
REQ-017 CHECK: frmData == FRAME_PATTERN increments match counter; on reaching MATCH_CYCLES -> LOCKED, aligned=1 on the next cycle.
REQ-018 CHECK mismatch: slip_count < MAX_SLIPS -> SLIP; slip_count == MAX_SLIPS -> FAIL.
REQ-019 SLIP: bitslip=1 for exactly one cycle (the only state where bitslip is high); slip_count increments by 1; -> SETTLE.
REQ-020 bitslip SHALL never be high on two consecutive cycles; minimum spacing is SETTLE_CYCLES+2 cycles.
REQ-021 LOCKED: aligned=1; each mismatch increments loss counter, any match clears it; loss counter reaching LOSS_CYCLES -> aligned=0, slip_count=0, -> SETTLE (automatic re-alignment).
REQ-022 FAIL: align_err=1, aligned=0, bitslip=0; held until align_start.
REQ-023 align_start in any state other than IDLE SHALL restart exactly as from IDLE (counters cleared, -> SETTLE), overriding the same-cycle transition; no bitslip issued that cycle.
REQ-024 slip_count SHALL saturate at MAX_SLIPS and never wrap.
REQ-025 Comparison SHALL be exact on all 8 bits; no partial or rotated matching inside the block.

Reset
REQ-026 rst_adc asserted SHALL force IDLE immediately (asynchronously) with bitslip=0, aligned=0, align_err=0, slip_count=0, all internal counters 0.
REQ-027 Reset asserted mid-SLIP SHALL drop bitslip in the same cycle; after deassertion the block waits for align_start.
REQ-028 Reset deassertion SHALL be consumed synchronously to adc_clk; no transition in the deassertion cycle.

Verification
REQ-029 frmData fixed 8'hF0, align_start at cycle 0 -> SETTLE cycles 1-4, CHECK 5-20, aligned=1 at cycle 21, zero bitslip pulses, slip_count=0.
REQ-030 Lane model rotating frmData by one bit per bitslip, initial 8'h1E -> exactly 3 single-cycle bitslip pulses each followed by 4 idle cycles, slip_count=3, aligned=1.
REQ-031 frmData fixed 8'h00 -> exactly 8 bitslip pulses, then align_err=1, aligned=0, slip_count=8; stays until align_start.
REQ-032 In LOCKED, 3 mismatching words then 8'hF0 -> aligned stays 1; 4 mismatching words -> aligned=0 next cycle, slip_count=0, re-lock without align_start.
REQ-033 rst_adc pulsed during SLIP and during SETTLE -> bitslip, aligned, align_err, slip_count all 0 immediately; no activity until align_start.
REQ-034 align_start during CHECK with match counter 10 and slip_count 2 -> slip_count=0, restart in SETTLE, lock after a full 4+16 cycles, no bitslip in the restart cycle.

Source files
------------

// File: rtl/frame_align.sv
// Frame-clock word aligner: issues ISERDES bitslip pulses until the deserialized
// frame word matches FRAME_PATTERN, then monitors lock and re-aligns on loss.
module frame_align #(
  parameter logic [7:0] FRAME_PATTERN = 8'hF0,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         MATCH_CYCLES  = 16,
  parameter int         MAX_SLIPS     = 8,
  parameter int         LOSS_CYCLES   = 4
) (
  input  logic       adc_clk,
  input  logic       rst_adc,
  input  logic       align_start,
  input  logic [7:0] frmData,
  output logic       bitslip,
  output logic       aligned,
  output logic       align_err,
  output logic [3:0] slip_count
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int MW = (MATCH_CYCLES > 1) ? $clog2(MATCH_CYCLES) : 1;
  localparam int LW = (LOSS_CYCLES > 1) ? $clog2(LOSS_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    SLIP,
    LOCKED,
    FAIL
  } state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   settle_reg, settle_next;
  logic [MW-1:0]   match_reg, match_next;
  logic [LW-1:0]   loss_reg, loss_next;
  logic [3:0]      slip_reg, slip_next;
  logic            bitslip_reg, bitslip_next;
  logic            aligned_reg, aligned_next;
  logic            err_reg, err_next;
  logic            pattern_hit;

  assign pattern_hit = (frmData == FRAME_PATTERN);

  always_ff @(posedge adc_clk or posedge rst_adc) begin
    if (rst_adc) begin
      state_reg   <= IDLE;
      settle_reg  <= '0;
      match_reg   <= '0;
      loss_reg    <= '0;
      slip_reg    <= '0;
      bitslip_reg <= 1'b0;
      aligned_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      settle_reg  <= settle_next;
      match_reg   <= match_next;
      loss_reg    <= loss_next;
      slip_reg    <= slip_next;
      bitslip_reg <= bitslip_next;
      aligned_reg <= aligned_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    settle_next  = settle_reg;
    match_next   = match_reg;
    loss_next    = loss_reg;
    slip_next    = slip_reg;
    bitslip_next = 1'b0;
    aligned_next = aligned_reg;
    err_next     = err_reg;

    case (state_reg)
      IDLE: ;
      SETTLE: begin
        if (settle_reg == SW'(SETTLE_CYCLES - 1)) begin
          state_next = CHECK;
          match_next = '0;
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end
      CHECK: begin
        if (pattern_hit) begin
          if (match_reg == MW'(MATCH_CYCLES - 1)) begin
            state_next   = LOCKED;
            aligned_next = 1'b1;
            loss_next    = '0;
          end else begin
            match_next = match_reg + 1'b1;
          end
        end else if (slip_reg < 4'(MAX_SLIPS)) begin
          // Slip count is bumped together with the pulse so it reads as "pulses issued".
          state_next   = SLIP;
          bitslip_next = 1'b1;
          slip_next    = slip_reg + 4'd1;
        end else begin
          state_next   = FAIL;
          err_next     = 1'b1;
          aligned_next = 1'b0;
        end
      end
      SLIP: begin
        state_next  = SETTLE;
        settle_next = '0;
      end
      LOCKED: begin
        if (pattern_hit) begin
          loss_next = '0;
        end else if (loss_reg == LW'(LOSS_CYCLES - 1)) begin
          state_next   = SETTLE;
          settle_next  = '0;
          loss_next    = '0;
          aligned_next = 1'b0;
          slip_next    = '0;
        end else begin
          loss_next = loss_reg + 1'b1;
        end
      end
      FAIL: ;
      default: state_next = IDLE;
    endcase

    // A start request wins over whatever the current state decided this cycle.
    if (align_start) begin
      state_next   = SETTLE;
      settle_next  = '0;
      match_next   = '0;
      loss_next    = '0;
      slip_next    = '0;
      bitslip_next = 1'b0;
      aligned_next = 1'b0;
      err_next     = 1'b0;
    end
  end

  assign bitslip    = bitslip_reg;
  assign aligned    = aligned_reg;
  assign align_err  = err_reg;
  assign slip_count = slip_reg;

endmodule
